// File: rtl/obi_resp_pkg.sv
// -----------------------------------------------------------------------------
// obi_resp_pkg
// Shared types and helpers for the OBI memory responder slice.
//   rsp_entry_t  : one queued response (read data + error flag)
//   addr_state_t : address-phase FSM states
//   be_merge()   : byte-enable merge of a write into an existing memory word
// -----------------------------------------------------------------------------
package obi_resp_pkg;

   localparam int BE_W = 4;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } rsp_entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      GRANT = 2'd2
   } addr_state_t;

   // Replace only the bytes whose enable bit is set.
   function automatic logic [31:0] be_merge(input logic [31:0]     old_word,
                                            input logic [31:0]     new_word,
                                            input logic [BE_W-1:0] be);
      logic [31:0] res;
      res = old_word;
      for (int i = 0; i < BE_W; i++) begin
         if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/obi_mem_responder_if.sv
// -----------------------------------------------------------------------------
// obi_mem_responder_if
// OBI address/response channel bundle.
//   master modport: drives req/addr/we/be/w_data/r_ready, sees gnt/r_valid/r_data/err
//   slave  modport: the mirror image, used by obi_mem_responder
// -----------------------------------------------------------------------------
interface obi_mem_responder_if
   import obi_resp_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();

   logic              req;
   logic              gnt;
   logic [ADDR_W-1:0] addr;
   logic              we;
   logic [BE_W-1:0]   be;
   logic [DATA_W-1:0] w_data;
   logic              r_valid;
   logic              r_ready;
   logic [DATA_W-1:0] r_data;
   logic              err;

   modport master (
      output req, addr, we, be, w_data, r_ready,
      input  gnt, r_valid, r_data, err
   );

   modport slave (
      input  req, addr, we, be, w_data, r_ready,
      output gnt, r_valid, r_data, err
   );

endinterface

// File: rtl/obi_resp_fifo.sv
// -----------------------------------------------------------------------------
// obi_resp_fifo
// Synchronous FIFO of rsp_entry_t holding in-order responses.
// Ports:
//   obi_aclk, obi_aresetn : clock, async active-low reset (pointers/count only)
//   push, push_entry      : write side (ignored when full)
//   pop                   : read side (ignored when empty)
//   head                  : entry at the read pointer (registered storage)
//   full, empty           : occupancy flags
// -----------------------------------------------------------------------------
module obi_resp_fifo
   import obi_resp_pkg::*;
#(
   parameter int RSP_DEPTH = 2
) (
   input  logic       obi_aclk,
   input  logic       obi_aresetn,
   input  logic       push,
   input  rsp_entry_t push_entry,
   input  logic       pop,
   output rsp_entry_t head,
   output logic       full,
   output logic       empty
);

   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RSP_DEPTH);

   rsp_entry_t       store [RSP_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
   endfunction

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = store[rd_ptr];

   always_ff @(posedge obi_aclk or negedge obi_aresetn) begin
      if (!obi_aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries data only; validity is tracked by count.
   always_ff @(posedge obi_aclk) begin
      if (do_push) store[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/obi_mem_responder.sv
// -----------------------------------------------------------------------------
// obi_mem_responder
// OBI responder backed by a single-port word memory. Grants address phases
// after a programmable number of wait states and returns responses in order
// through a small response FIFO.
// Ports:
//   obi_aclk, obi_aresetn : clock, async active-low reset
//   obi_slave             : OBI bus (slave modport of obi_mem_responder_if)
//   gnt_wait_cycles       : wait states before gnt, sampled when leaving IDLE
//   protocol_err          : sticky flag, set when req drops before gnt
// -----------------------------------------------------------------------------
module obi_mem_responder
   import obi_resp_pkg::*;
#(
   parameter int OBI_ADDR_WIDTH = 32,
   parameter int OBI_DATA_WIDTH = 32,
   parameter int MEM_WORDS      = 256,
   parameter int RSP_DEPTH      = 2
) (
   input  logic                      obi_aclk,
   input  logic                      obi_aresetn,
   obi_mem_responder_if.slave        obi_slave,
   input  logic [3:0]                gnt_wait_cycles,
   output logic                      protocol_err
);

   localparam int IDX_W = $clog2(MEM_WORDS);

   logic [OBI_DATA_WIDTH-1:0] mem [MEM_WORDS];

   addr_state_t      state;
   addr_state_t      state_nxt;
   logic [3:0]       wait_cnt;
   logic [3:0]       wait_cnt_nxt;
   logic             gnt;
   logic             proto_set;
   logic             accept;
   logic             in_range;
   logic [IDX_W-1:0] word_idx;
   logic             fifo_full;
   logic             fifo_empty;
   rsp_entry_t       push_entry;
   rsp_entry_t       head;

   // Byte address decode: bits [1:0] ignored, anything above the array is out of range.
   assign word_idx = obi_slave.addr[IDX_W+1:2];
   assign in_range = ~|obi_slave.addr[OBI_ADDR_WIDTH-1:IDX_W+2];

   // Address-phase FSM. The counter is loaded with N-1 so that gnt rises
   // exactly N cycles after req is first seen in IDLE; N==1 skips WAIT.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      gnt          = 1'b0;
      proto_set    = 1'b0;
      unique case (state)
         IDLE: begin
            if (obi_slave.req) begin
               if (gnt_wait_cycles == 4'd0) begin
                  gnt = !fifo_full;
               end else if (gnt_wait_cycles == 4'd1) begin
                  state_nxt = GRANT;
               end else begin
                  wait_cnt_nxt = gnt_wait_cycles - 4'd1;
                  state_nxt    = WAIT;
               end
            end
         end
         WAIT: begin
            if (!obi_slave.req) begin
               proto_set = 1'b1;
               state_nxt = IDLE;
            end else if (wait_cnt == 4'd1) begin
               // Counter parks at 1 while the FIFO is full.
               if (!fifo_full) state_nxt = GRANT;
            end else begin
               wait_cnt_nxt = wait_cnt - 4'd1;
            end
         end
         GRANT: begin
            if (!obi_slave.req) begin
               proto_set = 1'b1;
               state_nxt = IDLE;
            end else if (!fifo_full) begin
               gnt       = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge obi_aclk or negedge obi_aresetn) begin
      if (!obi_aresetn) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         protocol_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (proto_set) protocol_err <= 1'b1;
      end
   end

   // gnt is combinational from req; masking with reset keeps it low while held in reset.
   assign obi_slave.gnt = gnt && obi_aresetn;
   assign accept        = obi_slave.req && obi_slave.gnt;

   // Memory write at the accept edge; not reset so contents survive reset.
   always_ff @(posedge obi_aclk) begin
      if (accept && in_range && obi_slave.we) begin
         mem[word_idx] <= be_merge(mem[word_idx], obi_slave.w_data, obi_slave.be);
      end
   end

   // Read data is captured into the FIFO at the accept edge.
   always_comb begin
      push_entry      = '0;
      push_entry.err  = !in_range;
      if (in_range && !obi_slave.we) push_entry.data = mem[word_idx];
   end

   obi_resp_fifo #(
      .RSP_DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .obi_aclk    (obi_aclk),
      .obi_aresetn (obi_aresetn),
      .push        (accept),
      .push_entry  (push_entry),
      .pop         (obi_slave.r_ready),
      .head        (head),
      .full        (fifo_full),
      .empty       (fifo_empty)
   );

   // Head fields are zeroed when nothing is pending so the bus idles at 0.
   assign obi_slave.r_valid = !fifo_empty;
   assign obi_slave.r_data  = fifo_empty ? '0 : head.data;
   assign obi_slave.err     = !fifo_empty && head.err;

endmodule

// File: tb/tb_obi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_obi_mem_responder
// Self-checking bench for obi_mem_responder: directed scenarios plus a random
// phase, checked against a word-array / response-queue reference model.
// -----------------------------------------------------------------------------
module tb_obi_mem_responder;
   import obi_resp_pkg::*;

   localparam int MEM_WORDS = 256;
   localparam int RSP_DEPTH = 2;

   logic       obi_aclk = 1'b0;
   logic       obi_aresetn;
   logic [3:0] gnt_wait_cycles;
   logic       protocol_err;

   obi_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   obi_mem_responder #(
      .OBI_ADDR_WIDTH (32),
      .OBI_DATA_WIDTH (32),
      .MEM_WORDS      (MEM_WORDS),
      .RSP_DEPTH      (RSP_DEPTH)
   ) dut (
      .obi_aclk        (obi_aclk),
      .obi_aresetn     (obi_aresetn),
      .obi_slave       (bus.slave),
      .gnt_wait_cycles (gnt_wait_cycles),
      .protocol_err    (protocol_err)
   );

   always #5 obi_aclk = ~obi_aclk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic [31:0] ref_mem [MEM_WORDS];
   exp_t        exp_q [$];
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
      end
   endtask

   task automatic model_accept(input logic we, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] wdata);
      exp_t e;
      int   idx;
      if (addr >= MEM_WORDS * 4) begin
         e.data = 32'h0;
         e.err  = 1'b1;
      end else begin
         idx   = int'(addr / 4);
         e.err = 1'b0;
         if (we) begin
            for (int i = 0; i < 4; i++)
               if (be[i]) ref_mem[idx][8*i +: 8] = wdata[8*i +: 8];
            e.data = 32'h0;
         end else begin
            e.data = ref_mem[idx];
         end
      end
      exp_q.push_back(e);
   endtask

   // ---------------- response monitor ----------------
   logic        snap_hs    = 1'b0;
   logic [31:0] snap_data;
   logic        snap_err;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data;
   logic        prev_err;

   always @(negedge obi_aclk) begin
      #2;
      if (!obi_aresetn) begin
         snap_hs    = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("rsp_hold_valid", bus.r_valid, 1);
            chk("rsp_hold_data", bus.r_data, prev_data);
            chk("rsp_hold_err", bus.err, prev_err);
         end
         snap_hs    = bus.r_valid && bus.r_ready;
         snap_data  = bus.r_data;
         snap_err   = bus.err;
         prev_stall = bus.r_valid && !bus.r_ready;
         prev_data  = bus.r_data;
         prev_err   = bus.err;
      end
   end

   always @(posedge obi_aclk) begin
      exp_t e;
      if (snap_hs) begin
         snap_hs = 1'b0;
         chk("rsp_expected", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_data", snap_data, e.data);
            chk("rsp_err", snap_err, e.err);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input logic [3:0] wt, input bit rand_rdy,
                        output int waited);
      bit done;
      done   = 1'b0;
      waited = 0;
      @(negedge obi_aclk);
      gnt_wait_cycles = wt;
      bus.req    = 1'b1;
      bus.we     = we;
      bus.addr   = addr;
      bus.be     = be;
      bus.w_data = wdata;
      while (!done && waited < 200) begin
         if (rand_rdy) bus.r_ready = 1'($urandom_range(0, 1));
         #1;
         if (bus.gnt) begin
            model_accept(we, addr, be, wdata);
            @(posedge obi_aclk);
            done = 1'b1;
         end else begin
            waited++;
            @(negedge obi_aclk);
         end
      end
      chk("issue_granted", done, 1);
      if (!done) bus.req = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge obi_aclk);
         bus.req = 1'b0;
         bus.we  = 1'b0;
      end
   endtask

   task automatic drain();
      int k;
      @(negedge obi_aclk);
      bus.req     = 1'b0;
      bus.r_ready = 1'b1;
      k = 0;
      while (exp_q.size() != 0 && k < 50) begin
         @(negedge obi_aclk);
         k++;
      end
      #3;
      chk("drain_empty", exp_q.size(), 0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int w;
      logic [31:0] a;

      bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.be = '0; bus.w_data = '0;
      bus.r_ready = 1'b1;
      gnt_wait_cycles = 4'd0;
      obi_aresetn = 1'b0;

      // Reset state
      #1;
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_r_valid", bus.r_valid, 0);
      chk("rst_r_data", bus.r_data, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_protocol_err", protocol_err, 0);
      repeat (3) @(negedge obi_aclk);
      obi_aresetn = 1'b1;

      // Fill memory so the model knows every word
      for (int i = 0; i < MEM_WORDS; i++)
         issue(1'b1, 32'(i * 4), 4'hF, $urandom, 4'd0, 1'b0, w);
      drain();

      // Write/read with no wait states
      issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 4'd0, 1'b0, w);
      chk("wr_gnt_same_cycle", w, 0);
      #1 chk("wr_rvalid_next", bus.r_valid, 1);
      chk("wr_rsp_err", bus.err, 0);
      issue(1'b0, 32'h10, 4'h0, 32'h0, 4'd0, 1'b0, w);
      #1 chk("rd_deadbeef", bus.r_data, 32'hDEADBEEF);

      // Byte enables
      issue(1'b1, 32'h20, 4'hF, 32'h11223344, 4'd0, 1'b0, w);
      issue(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 4'd0, 1'b0, w);
      issue(1'b0, 32'h22, 4'h0, 32'h0, 4'd0, 1'b0, w);
      #1 chk("be_merge", bus.r_data, 32'h11BB33DD);
      drain();

      // Back-to-back throughput
      for (int i = 0; i < 8; i++) begin
         issue(1'b0, 32'($urandom_range(0, MEM_WORDS - 1) * 4), 4'h0, 32'h0, 4'd0, 1'b0, w);
         chk("b2b_no_wait", w, 0);
      end
      drain();

      // Wait states: gnt exactly 3 cycles after req
      @(negedge obi_aclk);
      gnt_wait_cycles = 4'd3;
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h10;
      for (int c = 0; c < 4; c++) begin
         #1 chk($sformatf("wait3_gnt_c%0d", c), bus.gnt, (c == 3));
         if (c < 3) @(negedge obi_aclk);
      end
      if (bus.gnt) begin
         model_accept(1'b0, 32'h10, 4'h0, 32'h0);
         @(posedge obi_aclk);
      end
      idle(1);

      // Req dropped during WAIT
      @(negedge obi_aclk);
      gnt_wait_cycles = 4'd3;
      bus.req = 1'b1;
      @(negedge obi_aclk);
      bus.req = 1'b0;
      #1 chk("drop_no_gnt", bus.gnt, 0);
      @(negedge obi_aclk);
      #1 chk("drop_protocol_err", protocol_err, 1);
      issue(1'b0, 32'h20, 4'h0, 32'h0, 4'd0, 1'b0, w);
      chk("drop_back_to_idle", w, 0);
      drain();

      // Backpressure with a 2-deep FIFO
      @(negedge obi_aclk);
      bus.r_ready = 1'b0;
      issue(1'b0, 32'h10, 4'h0, 32'h0, 4'd0, 1'b0, w);
      chk("bp_first_gnt", w, 0);
      issue(1'b0, 32'h20, 4'h0, 32'h0, 4'd0, 1'b0, w);
      chk("bp_second_gnt", w, 0);
      @(negedge obi_aclk);
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h30;
      for (int k = 0; k < 3; k++) begin
         #1 chk("bp_third_blocked", bus.gnt, 0);
         @(negedge obi_aclk);
      end
      bus.r_ready = 1'b1;
      #1 chk("bp_no_bypass", bus.gnt, 0);
      issue(1'b0, 32'h30, 4'h0, 32'h0, 4'd0, 1'b0, w);
      chk("bp_third_gnt", w, 0);
      drain();

      // Out of range
      issue(1'b0, 32'h400, 4'h0, 32'h0, 4'd0, 1'b0, w);
      #1 chk("oor_rd_err", bus.err, 1);
      chk("oor_rd_data", bus.r_data, 0);
      issue(1'b1, 32'h400, 4'hF, 32'hFEEDFACE, 4'd0, 1'b0, w);
      #1 chk("oor_wr_err", bus.err, 1);
      issue(1'b1, 32'hFFFF_FFF0, 4'hF, 32'h0BADF00D, 4'd0, 1'b0, w);
      for (int i = 0; i < MEM_WORDS; i++)
         issue(1'b0, 32'(i * 4), 4'h0, 32'h0, 4'd0, 1'b0, w);
      drain();

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         a = 32'($urandom_range(0, 32'h47F));
         issue(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom,
               4'($urandom_range(0, 3)), 1'b1, w);
      end
      drain();

      // Reset with two responses pending
      issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 4'd0, 1'b0, w);
      drain();
      @(negedge obi_aclk);
      bus.r_ready = 1'b0;
      issue(1'b0, 32'h10, 4'h0, 32'h0, 4'd0, 1'b0, w);
      issue(1'b0, 32'h20, 4'h0, 32'h0, 4'd0, 1'b0, w);
      @(negedge obi_aclk);
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h30;
      gnt_wait_cycles = 4'd0;
      obi_aresetn = 1'b0;
      #1;
      chk("mid_rst_r_valid", bus.r_valid, 0);
      chk("mid_rst_gnt", bus.gnt, 0);
      chk("mid_rst_r_data", bus.r_data, 0);
      chk("mid_rst_protocol_err", protocol_err, 0);
      exp_q.delete();
      repeat (2) @(negedge obi_aclk);
      obi_aresetn = 1'b1;
      bus.req = 1'b0;
      bus.r_ready = 1'b1;
      #1 chk("post_rst_fifo_empty", bus.r_valid, 0);
      issue(1'b0, 32'h10, 4'h0, 32'h0, 4'd0, 1'b0, w);
      chk("post_rst_idle_gnt", w, 0);
      #1 chk("post_rst_mem_kept", bus.r_data, 32'hDEADBEEF);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
